// File: rtl/dac_test_pkg.sv
// Shared types and constants for the composite video DAC scheduler.
package dac_test_pkg;

   typedef enum logic [1:0] {
      PAT_SAW    = 2'd0,
      PAT_SQUARE = 2'd1,
      PAT_STAIR  = 2'd2,
      PAT_MID    = 2'd3
   } pattern_e;

   typedef enum logic [2:0] {
      StAuto     = 3'd0,
      StHold     = 3'd1,
      StGuardIn  = 3'd2,
      StExt      = 3'd3,
      StGuardOut = 3'd4
   } sched_state_e;

   localparam logic [7:0] BLANK_LEVEL    = 8'h00;
   localparam logic [7:0] MID_LEVEL      = 8'h80;
   localparam logic [7:0] CMD_AUTO       = 8'hFF;
   localparam logic [2:0] PATTERN_ID_EXT = 3'd7;

   // Bytes 0x00..0x03 select a held pattern.
   function automatic logic is_hold_cmd(input logic [7:0] b);
      return (b[7:2] == 6'd0);
   endfunction

   // AUTO rotation order, wraps 3 -> 0.
   function automatic pattern_e next_pattern(input pattern_e p);
      return pattern_e'(p + 2'd1);
   endfunction

endpackage

// File: rtl/dac_pattern_gen.sv
// Free-running test pattern sources; all four codes are presented combinationally.
module dac_pattern_gen
   import dac_test_pkg::*;
#(
   parameter int unsigned RAMP_SHIFT         = 3,
   parameter int unsigned SQUARE_HALF_PERIOD = 1024
) (
   input  logic       i_clk,
   input  logic       i_rst,
   output logic [7:0] o_saw,
   output logic [7:0] o_square,
   output logic [7:0] o_stair,
   output logic [7:0] o_mid
);

   localparam int unsigned RampW = RAMP_SHIFT + 8;
   localparam int unsigned SqW   = $clog2(SQUARE_HALF_PERIOD + 1);

   logic [RampW-1:0] r_ramp;
   logic [SqW-1:0]   r_sq_cnt;
   logic             r_sq_lvl;
   logic [2:0]       w_step;

   // Ramp counter and square half-period timer, both restart on reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ramp   <= '0;
         r_sq_cnt <= '0;
         r_sq_lvl <= 1'b0;
      end else begin
         r_ramp <= r_ramp + RampW'(1);
         if (r_sq_cnt == SqW'(SQUARE_HALF_PERIOD - 1)) begin
            r_sq_cnt <= '0;
            r_sq_lvl <= ~r_sq_lvl;
         end else begin
            r_sq_cnt <= r_sq_cnt + SqW'(1);
         end
      end
   end

   // Pattern codes derived from the counters.
   always_comb begin
      w_step   = r_ramp[RAMP_SHIFT+7:RAMP_SHIFT+5];
      o_saw    = r_ramp[RAMP_SHIFT+7:RAMP_SHIFT];
      o_square = {8{r_sq_lvl}};
      o_stair  = {w_step, w_step, w_step[2:1]};
      o_mid    = MID_LEVEL;
   end

endmodule

// File: rtl/dac_pattern_scheduler.sv
// Chooses each clock which source drives the video DAC: a test pattern or the external requester.
module dac_pattern_scheduler
   import dac_test_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES       = 27_000_000,
   parameter int unsigned GUARD_CYCLES       = 64,
   parameter int unsigned RAMP_SHIFT         = 3,
   parameter int unsigned SQUARE_HALF_PERIOD = 1024
) (
   input  logic       i_clk27,
   input  logic       i_rst,
   input  logic       i_ext_req,
   input  logic [7:0] i_ext_data,
   output logic       o_ext_grant,
   input  logic       i_cmd_valid,
   input  logic [7:0] i_cmd_byte,
   output logic [7:0] o_video,
   output logic [1:0] o_video_extra,
   output logic [2:0] o_pattern_id
);

   localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
   localparam int unsigned GuardW = $clog2(GUARD_CYCLES + 1);

   sched_state_e      r_state, w_state_d;
   pattern_e          r_pattern, w_pattern_d;
   logic              r_mode_auto, w_mode_auto_d;
   logic [DwellW-1:0] r_dwell, w_dwell_d;
   logic [GuardW-1:0] r_guard, w_guard_d;
   logic [7:0]        r_video, w_video_d;
   logic [2:0]        r_pattern_id, w_pattern_id_d;

   logic         w_cmd_auto, w_cmd_hold, w_guard_end;
   sched_state_e w_resume;
   logic [7:0]   w_saw, w_square, w_stair, w_mid, w_pat_code;

   dac_pattern_gen #(
      .RAMP_SHIFT         (RAMP_SHIFT),
      .SQUARE_HALF_PERIOD (SQUARE_HALF_PERIOD)
   ) u_gen (
      .i_clk    (i_clk27),
      .i_rst    (i_rst),
      .o_saw    (w_saw),
      .o_square (w_square),
      .o_stair  (w_stair),
      .o_mid    (w_mid)
   );

   assign w_cmd_auto  = i_cmd_valid && (i_cmd_byte == CMD_AUTO);
   assign w_cmd_hold  = i_cmd_valid && is_hold_cmd(i_cmd_byte);
   assign w_guard_end = (r_guard == GuardW'(GUARD_CYCLES - 1));
   assign w_resume    = w_mode_auto_d ? StAuto : StHold;

   // State register and all registered datapath/outputs.
   always_ff @(posedge i_clk27) begin
      if (i_rst) begin
         r_state      <= StAuto;
         r_pattern    <= PAT_SAW;
         r_mode_auto  <= 1'b1;
         r_dwell      <= '0;
         r_guard      <= '0;
         r_video      <= BLANK_LEVEL;
         r_pattern_id <= 3'd0;
      end else begin
         r_state      <= w_state_d;
         r_pattern    <= w_pattern_d;
         r_mode_auto  <= w_mode_auto_d;
         r_dwell      <= w_dwell_d;
         r_guard      <= w_guard_d;
         r_video      <= w_video_d;
         r_pattern_id <= w_pattern_id_d;
      end
   end

   // Saved mode/pattern and dwell timing; commands win over a same-cycle dwell expiry.
   always_comb begin
      w_pattern_d   = r_pattern;
      w_mode_auto_d = r_mode_auto;
      w_dwell_d     = r_dwell;
      if (r_state == StAuto) begin
         if (r_dwell == DwellW'(DWELL_CYCLES - 1)) begin
            w_dwell_d   = '0;
            w_pattern_d = next_pattern(r_pattern);
         end else begin
            w_dwell_d = r_dwell + DwellW'(1);
         end
      end
      if (w_cmd_auto) begin
         w_mode_auto_d = 1'b1;
         w_dwell_d     = '0;
      end else if (w_cmd_hold) begin
         w_mode_auto_d = 1'b0;
         w_pattern_d   = pattern_e'(i_cmd_byte[1:0]);
         w_dwell_d     = '0;
      end
   end

   // Next-state logic for ownership hand-over with blanking guards.
   always_comb begin
      w_state_d = r_state;
      w_guard_d = r_guard;
      case (r_state)
         StAuto, StHold: begin
            w_guard_d = '0;
            w_state_d = i_ext_req ? StGuardIn : w_resume;
         end
         StGuardIn: begin
            if (!i_ext_req) begin
               w_state_d = w_resume;
               w_guard_d = '0;
            end else if (w_guard_end) begin
               w_state_d = StExt;
               w_guard_d = '0;
            end else begin
               w_guard_d = r_guard + GuardW'(1);
            end
         end
         StExt: begin
            w_guard_d = '0;
            if (!i_ext_req) w_state_d = StGuardOut;
         end
         StGuardOut: begin
            if (w_guard_end) begin
               // Always finish the outgoing guard before re-requesting the DAC.
               w_state_d = i_ext_req ? StGuardIn : w_resume;
               w_guard_d = '0;
            end else begin
               w_guard_d = r_guard + GuardW'(1);
            end
         end
         default: begin
            w_state_d = StAuto;
            w_guard_d = '0;
         end
      endcase
   end

   // Output selection from the registered state and pattern.
   always_comb begin
      w_pat_code = w_saw;
      case (r_pattern)
         PAT_SAW:    w_pat_code = w_saw;
         PAT_SQUARE: w_pat_code = w_square;
         PAT_STAIR:  w_pat_code = w_stair;
         PAT_MID:    w_pat_code = w_mid;
      endcase
      w_video_d      = BLANK_LEVEL;
      w_pattern_id_d = PATTERN_ID_EXT;
      case (r_state)
         StAuto, StHold: begin
            w_video_d      = w_pat_code;
            w_pattern_id_d = {1'b0, r_pattern};
         end
         StExt:   w_video_d = i_ext_data;
         default: w_video_d = BLANK_LEVEL;
      endcase
   end

   assign o_ext_grant   = (r_state == StExt);
   assign o_video       = r_video;
   assign o_video_extra = r_video[7:6];
   assign o_pattern_id  = r_pattern_id;

endmodule

// File: tb/tb_dac_pattern_scheduler.sv
// Directed bench for dac_pattern_scheduler with short dwell/guard/square timing.
module tb_dac_pattern_scheduler;

   logic       clk27 = 1'b0;
   logic       rst = 1'b1;
   logic       ext_req = 1'b0;
   logic [7:0] ext_data = 8'h00;
   logic       ext_grant;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_byte = 8'h00;
   logic [7:0] video;
   logic [1:0] video_extra;
   logic [2:0] pattern_id;

   int total = 0;
   int bad = 0;
   int edge_n = 0;
   int base = 1;

   dac_pattern_scheduler #(
      .DWELL_CYCLES       (16),
      .GUARD_CYCLES       (4),
      .RAMP_SHIFT         (0),
      .SQUARE_HALF_PERIOD (4)
   ) dut (
      .i_clk27       (clk27),
      .i_rst         (rst),
      .i_ext_req     (ext_req),
      .i_ext_data    (ext_data),
      .o_ext_grant   (ext_grant),
      .i_cmd_valid   (cmd_valid),
      .i_cmd_byte    (cmd_byte),
      .o_video       (video),
      .o_video_extra (video_extra),
      .o_pattern_id  (pattern_id)
   );

   initial forever #5 clk27 = ~clk27;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, edge_n, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] v, input logic [2:0] p,
                          input logic g);
      chk({tag, ".video"}, {24'd0, video}, {24'd0, v});
      chk({tag, ".extra"}, {30'd0, video_extra}, {30'd0, v[7:6]});
      chk({tag, ".pid"}, {29'd0, pattern_id}, {29'd0, p});
      chk({tag, ".grant"}, {31'd0, ext_grant}, {31'd0, g});
   endtask

   // Advance one clock and sample just after the edge.
   task automatic step();
      @(posedge clk27);
      #1;
      edge_n++;
   endtask

   // Ramp value that fed the edge just taken (ramp is 0 on the first edge after reset).
   function automatic logic [7:0] saw_exp();
      return 8'(edge_n - base);
   endfunction

   function automatic logic [7:0] sq_exp();
      return ((((edge_n - base) / 4) % 2) == 1) ? 8'hFF : 8'h00;
   endfunction

   initial begin
      // Reset state
      repeat (3) step();
      chk_out("reset", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      base = edge_n + 1;

      // Free-running AUTO rotation: saw, square, stair, mid, saw
      for (int n = 0; n < 70; n++) begin
         step();
         case (n / 16)
            0:       chk_out("auto_saw", saw_exp(), 3'd0, 1'b0);
            1:       chk_out("auto_sq", sq_exp(), 3'd1, 1'b0);
            2:       chk_out("auto_stair", 8'h24, 3'd2, 1'b0);
            3:       chk_out("auto_mid", 8'h80, 3'd3, 1'b0);
            default: chk_out("auto_wrap", saw_exp(), 3'd0, 1'b0);
         endcase
      end

      // Hold MID
      cmd_valid = 1'b1;
      cmd_byte  = 8'h03;
      step();
      chk_out("hold3_edge", 8'h46, 3'd0, 1'b0);
      cmd_valid = 1'b0;
      for (int i = 0; i < 110; i++) begin
         step();
         chk_out("hold3", 8'h80, 3'd3, 1'b0);
      end

      // Unrecognised command is ignored
      cmd_valid = 1'b1;
      cmd_byte  = 8'h42;
      step();
      cmd_valid = 1'b0;
      chk_out("ign42_edge", 8'h80, 3'd3, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk_out("ign42", 8'h80, 3'd3, 1'b0);
      end

      // Back to AUTO: MID stays for a full dwell, then saw
      cmd_valid = 1'b1;
      cmd_byte  = 8'hFF;
      step();
      chk_out("autocmd_edge", 8'h80, 3'd3, 1'b0);
      cmd_valid = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         chk_out("autocmd_dwell", 8'h80, 3'd3, 1'b0);
      end
      step();
      chk_out("autocmd_adv", saw_exp(), 3'd0, 1'b0);

      cmd_valid = 1'b1;
      cmd_byte  = 8'h03;
      step();
      chk_out("rehold_edge", saw_exp(), 3'd0, 1'b0);
      cmd_valid = 1'b0;
      step();
      chk_out("rehold", 8'h80, 3'd3, 1'b0);

      // External tenure from HOLD(3)
      ext_req  = 1'b1;
      ext_data = 8'h5A;
      step();
      chk_out("ext_req_edge", 8'h80, 3'd3, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk_out("guard_in", 8'h00, 3'd7, (i == 4));
      end
      step();
      chk_out("ext_5a", 8'h5A, 3'd7, 1'b1);
      ext_data = 8'h33;
      step();
      chk_out("ext_33", 8'h33, 3'd7, 1'b1);
      step();
      chk_out("ext_33b", 8'h33, 3'd7, 1'b1);
      ext_req = 1'b0;
      step();
      chk_out("ext_rel", 8'h33, 3'd7, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out("guard_out", 8'h00, 3'd7, 1'b0);
      end
      step();
      chk_out("ext_back", 8'h80, 3'd3, 1'b0);

      // Two-clock request pulse aborts in the guard
      ext_req = 1'b1;
      step();
      chk_out("abort_p0", 8'h80, 3'd3, 1'b0);
      step();
      chk_out("abort_p1", 8'h00, 3'd7, 1'b0);
      ext_req = 1'b0;
      step();
      chk_out("abort_p2", 8'h00, 3'd7, 1'b0);
      step();
      chk_out("abort_back", 8'h80, 3'd3, 1'b0);
      step();
      chk_out("abort_back2", 8'h80, 3'd3, 1'b0);

      // Command during EXT is deferred until the guard ends
      ext_req  = 1'b1;
      ext_data = 8'h11;
      step();
      chk_out("def_req", 8'h80, 3'd3, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk_out("def_guard_in", 8'h00, 3'd7, (i == 4));
      end
      step();
      chk_out("def_ext", 8'h11, 3'd7, 1'b1);
      cmd_valid = 1'b1;
      cmd_byte  = 8'h01;
      step();
      chk_out("def_cmd", 8'h11, 3'd7, 1'b1);
      cmd_valid = 1'b0;
      step();
      chk_out("def_ext2", 8'h11, 3'd7, 1'b1);
      ext_data = 8'h22;
      step();
      chk_out("def_ext3", 8'h22, 3'd7, 1'b1);
      ext_req = 1'b0;
      step();
      chk_out("def_rel", 8'h22, 3'd7, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out("def_guard_out", 8'h00, 3'd7, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         chk_out("def_square", sq_exp(), 3'd1, 1'b0);
      end

      // Reset while the external source owns the DAC
      ext_req  = 1'b1;
      ext_data = 8'h44;
      step();
      chk_out("rst_req", sq_exp(), 3'd1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk_out("rst_guard_in", 8'h00, 3'd7, (i == 4));
      end
      step();
      chk_out("rst_ext", 8'h44, 3'd7, 1'b1);
      rst = 1'b1;
      step();
      chk_out("rst_in_ext", 8'h00, 3'd0, 1'b0);
      rst     = 1'b0;
      ext_req = 1'b0;
      base    = edge_n + 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out("rst_saw", saw_exp(), 3'd0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
